alarm_out_sequencer: RTL and testbench

- Avalon-MM slave that sequences the 2-bit alarm output (buzzer / LED pair) autonomously, so the Nios II core no longer bit-bangs a plain PIO.
- Software loads a 4-step pattern, a step period and a repeat count, then starts it. The block steps the pattern in hardware and raises an interrupt on completion.
- Sits on the CPU data bus beside the other peripherals. out_port goes to the board pins.

---
 rtl/alarm_out_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_alarm_out_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_out_sequencer.sv
// Alarm output sequencer: Avalon-MM slave that plays a 4-step, 2-bit pattern on
// out_port with a programmable step period and pass count, then raises DONE/irq.
module alarm_out_sequencer #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  out_port,
  output logic        irq
);

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(DEFAULT_PERIOD);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic                r_loop;
  logic                r_irqEn;
  logic                r_done;
  logic [PERIOD_W-1:0] r_period;
  logic [7:0]          r_pattern;
  logic [7:0]          r_repeat;
  logic [1:0]          r_idleOut;

  logic [1:0]          r_step;
  logic [PERIOD_W-1:0] r_cycle;
  logic [PERIOD_W-1:0] r_curPeriod;
  logic [7:0]          r_pass;
  logic [1:0]          r_out;

  logic [1:0]          w_stepNext;
  logic [PERIOD_W-1:0] w_cycleNext;
  logic [PERIOD_W-1:0] w_curPeriodNext;
  logic [7:0]          w_passNext;
  logic [1:0]          w_outNext;
  logic                w_setDone;

  logic w_wr;
  logic w_wrCtrl;
  logic w_wrPeriod;
  logic w_wrPattern;
  logic w_wrRepeat;
  logic w_wrStatus;
  logic w_wrIdleOut;
  logic w_startReq;
  logic w_stopReq;
  logic w_startOk;
  logic w_loopNow;
  logic [1:0] w_idleOutNow;
  logic w_running;
  logic w_stepLast;
  logic w_morePasses;
  logic [1:0] w_stepInc;
  logic [7:0] w_passInc;
  logic w_unusedBits;

  assign w_wr        = chipselect & ~write_n;
  assign w_wrCtrl    = w_wr & (address == 3'd0);
  assign w_wrPeriod  = w_wr & (address == 3'd1);
  assign w_wrPattern = w_wr & (address == 3'd2);
  assign w_wrRepeat  = w_wr & (address == 3'd3);
  assign w_wrStatus  = w_wr & (address == 3'd4);
  assign w_wrIdleOut = w_wr & (address == 3'd5);

  assign w_startReq = w_wrCtrl & writedata[0];
  assign w_stopReq  = w_wrCtrl & writedata[1];

  // LOOP and IDLE_OUT written on this edge already count for decisions made on it.
  assign w_loopNow    = w_wrCtrl ? writedata[2] : r_loop;
  assign w_idleOutNow = w_wrIdleOut ? writedata[1:0] : r_idleOut;

  assign w_startOk = w_startReq & ~w_stopReq & (r_period != '0) &
                     ((r_repeat != 8'd0) | w_loopNow);

  assign w_running    = (r_state == ST_RUN);
  assign w_stepLast   = (r_curPeriod == '0) || (r_cycle >= (r_curPeriod - PERIOD_ONE));
  assign w_stepInc    = r_step + 2'd1;
  assign w_passInc    = (r_pass == 8'hFF) ? r_pass : (r_pass + 8'd1);
  assign w_morePasses = ({1'b0, r_pass} + 9'd1) < {1'b0, r_repeat};

  assign w_unusedBits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loop    <= 1'b0;
      r_irqEn   <= 1'b0;
      r_period  <= PERIOD_RST;
      r_pattern <= 8'd0;
      r_repeat  <= 8'd0;
      r_idleOut <= 2'd0;
      r_done    <= 1'b0;
    end else begin
      if (w_wrCtrl) begin
        r_loop  <= writedata[2];
        r_irqEn <= writedata[3];
      end
      if (w_wrPeriod) begin
        r_period <= writedata[PERIOD_W-1:0];
      end
      if (w_wrPattern) begin
        r_pattern <= writedata[7:0];
      end
      if (w_wrRepeat) begin
        r_repeat <= writedata[7:0];
      end
      if (w_wrIdleOut) begin
        r_idleOut <= writedata[1:0];
      end
      // Completion beats a software clear landing on the same edge.
      if (w_setDone) begin
        r_done <= 1'b1;
      end else if (w_wrStatus && writedata[1]) begin
        r_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_step      <= 2'd0;
      r_cycle     <= '0;
      r_curPeriod <= '0;
      r_pass      <= 8'd0;
      r_out       <= 2'd0;
    end else begin
      r_state     <= w_stateNext;
      r_step      <= w_stepNext;
      r_cycle     <= w_cycleNext;
      r_curPeriod <= w_curPeriodNext;
      r_pass      <= w_passNext;
      r_out       <= w_outNext;
    end
  end

  // The step period is latched at start and at every boundary, so mid-step
  // PERIOD writes only shape the following step.
  always_comb begin
    w_stateNext     = r_state;
    w_stepNext      = r_step;
    w_cycleNext     = r_cycle;
    w_curPeriodNext = r_curPeriod;
    w_passNext      = r_pass;
    w_outNext       = r_out;
    w_setDone       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_outNext = w_idleOutNow;
        if (w_startOk) begin
          w_stateNext     = ST_RUN;
          w_stepNext      = 2'd0;
          w_cycleNext     = '0;
          w_curPeriodNext = r_period;
          w_passNext      = 8'd0;
          w_outNext       = r_pattern[1:0];
        end
      end

      ST_RUN: begin
        if (w_stopReq) begin
          w_stateNext = ST_IDLE;
          w_outNext   = w_idleOutNow;
        end else if (w_startOk) begin
          w_stepNext      = 2'd0;
          w_cycleNext     = '0;
          w_curPeriodNext = r_period;
          w_passNext      = 8'd0;
          w_outNext       = r_pattern[1:0];
        end else if (w_stepLast) begin
          w_cycleNext     = '0;
          w_curPeriodNext = r_period;
          if (r_step == 2'd3) begin
            w_passNext = w_passInc;
            if (w_loopNow || w_morePasses) begin
              w_stepNext = 2'd0;
              w_outNext  = r_pattern[1:0];
            end else begin
              w_stateNext = ST_IDLE;
              w_outNext   = w_idleOutNow;
              w_setDone   = 1'b1;
            end
          end else begin
            w_stepNext = w_stepInc;
            w_outNext  = r_pattern[{w_stepInc, 1'b0} +: 2];
          end
        end else begin
          w_cycleNext = r_cycle + PERIOD_ONE;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0:    readdata = {28'd0, r_irqEn, r_loop, 1'b0, w_running};
      3'd1:    readdata = 32'(r_period);
      3'd2:    readdata = {24'd0, r_pattern};
      3'd3:    readdata = {24'd0, r_repeat};
      3'd4:    readdata = {30'd0, r_done, w_running};
      3'd5:    readdata = {30'd0, r_idleOut};
      default: readdata = 32'd0;
    endcase
  end

  assign out_port = r_out;
  assign irq      = r_done & r_irqEn;

endmodule

// File: tb/tb_alarm_out_sequencer.sv
// Testbench for alarm_out_sequencer: directed register programming with
// hand-computed expectations queued per cycle and checked by a separate monitor.
module tb_alarm_out_sequencer;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  out_port;
  logic        irq;

  localparam int SEL_OUT  = 0;
  localparam int SEL_IRQ  = 1;
  localparam int SEL_READ = 2;

  typedef struct {
    int          cycle;
    int          sel;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  alarm_out_sequencer #(
    .PERIOD_W(24),
    .DEFAULT_PERIOD(50000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due in the current cycle at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
      e = expQ.pop_front();
      case (e.sel)
        SEL_OUT: act = {30'd0, out_port};
        SEL_IRQ: act = {31'd0, irq};
        default: act = readdata;
      endcase
      nChecks++;
      if (e.cycle != cyc) begin
        $display("[TB] FAIL %s: expectation for cycle %0d sampled late at %0d", e.name, e.cycle, cyc);
      end else if (act !== e.value) begin
        $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", e.name, cyc, act, e.value);
      end else begin
        nPass++;
      end
    end
  end

  initial begin
    #100000;
    nChecks++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queues an expected value for cycle (current + offset).
  task automatic checkOutput(input int sel, input int offset, input logic [31:0] value, input string name);
    exp_t e;
    e.cycle = cyc + offset;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    expQ.push_back(e);
  endtask

  // Bus write: captured on the next rising edge; returns just after that edge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [2:0] addr, input logic [31:0] value, input string name);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    checkOutput(SEL_READ, 0, value, name);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  localparam logic [1:0] PAT_E4 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [1:0] PAT_1B [4] = '{2'd3, 2'd2, 2'd1, 2'd0};

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    waitCycles(3);
    reset_n = 1'b1;
    checkOutput(SEL_OUT, 0, 32'd0, "initOut");
    checkOutput(SEL_IRQ, 0, 32'd0, "initIrq");
    readReg(3'd1, 32'd50000, "initPeriod");

    $display("[TB] single pass");
    applyStimulus(3'd1, 32'd3);
    applyStimulus(3'd2, 32'hE4);
    applyStimulus(3'd3, 32'd1);
    applyStimulus(3'd5, 32'd0);
    applyStimulus(3'd0, 32'h1);
    for (int k = 0; k < 12; k++) begin
      checkOutput(SEL_OUT, k, {30'd0, PAT_E4[k / 3]}, "singleStep");
    end
    checkOutput(SEL_OUT, 12, 32'd0, "singleIdleOut");
    checkOutput(SEL_IRQ, 12, 32'd0, "singleIrqMasked");
    waitCycles(12);
    readReg(3'd4, 32'h2, "singleStatusDone");
    applyStimulus(3'd4, 32'h2);
    readReg(3'd4, 32'h0, "singleDoneCleared");

    $display("[TB] repeat with irq");
    applyStimulus(3'd1, 32'd2);
    applyStimulus(3'd2, 32'h1B);
    applyStimulus(3'd3, 32'd2);
    applyStimulus(3'd0, 32'h9);
    for (int k = 0; k < 16; k++) begin
      checkOutput(SEL_OUT, k, {30'd0, PAT_1B[(k / 2) % 4]}, "repeatStep");
    end
    checkOutput(SEL_IRQ, 15, 32'd0, "repeatIrqBeforeDone");
    checkOutput(SEL_OUT, 16, 32'd0, "repeatIdleOut");
    checkOutput(SEL_IRQ, 16, 32'd1, "repeatIrqSet");
    waitCycles(16);
    applyStimulus(3'd4, 32'h2);
    checkOutput(SEL_IRQ, 0, 32'd0, "repeatIrqCleared");

    $display("[TB] stop in loop");
    applyStimulus(3'd5, 32'd2);
    checkOutput(SEL_OUT, 0, 32'd2, "idleOutVisible");
    applyStimulus(3'd1, 32'd4);
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd0, 32'h5);
    checkOutput(SEL_OUT, 0, 32'd3, "loopFirst");
    waitCycles(100);
    checkOutput(SEL_OUT, 0, 32'd3, "loopAfter100");
    readReg(3'd0, 32'h5, "loopCtrlRunning");
    applyStimulus(3'd0, 32'h6);
    checkOutput(SEL_OUT, 0, 32'd2, "stopIdleOut");
    readReg(3'd4, 32'h0, "stopNoDone");

    $display("[TB] illegal start");
    applyStimulus(3'd0, 32'h0);
    applyStimulus(3'd1, 32'd0);
    applyStimulus(3'd0, 32'h1);
    checkOutput(SEL_OUT, 0, 32'd2, "zeroPeriodOut");
    readReg(3'd4, 32'h0, "zeroPeriodStatus");
    applyStimulus(3'd1, 32'd3);
    applyStimulus(3'd3, 32'd0);
    applyStimulus(3'd0, 32'h1);
    checkOutput(SEL_OUT, 0, 32'd2, "zeroRepeatOut");
    readReg(3'd4, 32'h0, "zeroRepeatStatus");
    applyStimulus(3'd3, 32'd1);
    applyStimulus(3'd0, 32'h3);
    readReg(3'd4, 32'h0, "startStopStatus");

    $display("[TB] live update and retrigger");
    applyStimulus(3'd2, 32'hE4);
    applyStimulus(3'd0, 32'h1);
    for (int k = 0; k < 4; k++) begin
      checkOutput(SEL_OUT, k, {30'd0, PAT_E4[k / 3]}, "liveStep");
    end
    waitCycles(3);
    applyStimulus(3'd2, 32'h00);
    checkOutput(SEL_OUT, 0, 32'd1, "liveStep1Hold");
    checkOutput(SEL_OUT, 1, 32'd1, "liveStep1End");
    checkOutput(SEL_OUT, 2, 32'd0, "liveStep2New");
    checkOutput(SEL_OUT, 3, 32'd0, "liveStep2Hold");
    waitCycles(2);
    applyStimulus(3'd2, 32'h1B);
    applyStimulus(3'd0, 32'h1);
    for (int k = 0; k < 3; k++) begin
      checkOutput(SEL_OUT, k, 32'd3, "retrigStep0");
    end
    checkOutput(SEL_OUT, 3, 32'd2, "retrigStep1");
    checkOutput(SEL_OUT, 5, 32'd2, "retrigStep1End");
    checkOutput(SEL_OUT, 6, 32'd1, "retrigStep2");
    waitCycles(7);
    applyStimulus(3'd0, 32'h2);
    checkOutput(SEL_OUT, 0, 32'd2, "retrigStopped");

    $display("[TB] reset mid-run");
    applyStimulus(3'd1, 32'd2);
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd0, 32'h9);
    waitCycles(8);
    checkOutput(SEL_IRQ, 0, 32'd1, "preResetIrq");
    checkOutput(SEL_OUT, 0, 32'd2, "preResetIdle");
    applyStimulus(3'd0, 32'hD);
    checkOutput(SEL_OUT, 0, 32'd3, "preResetRun");
    checkOutput(SEL_IRQ, 0, 32'd1, "preResetIrqHeld");
    waitCycles(3);
    reset_n = 1'b0;
    checkOutput(SEL_OUT, 0, 32'd0, "resetOut");
    checkOutput(SEL_IRQ, 0, 32'd0, "resetIrq");
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(1);
    readReg(3'd0, 32'd0, "rstCtrl");
    readReg(3'd1, 32'd50000, "rstPeriod");
    readReg(3'd2, 32'd0, "rstPattern");
    readReg(3'd3, 32'd0, "rstRepeat");
    readReg(3'd4, 32'd0, "rstStatus");
    readReg(3'd5, 32'd0, "rstIdleOut");
    readReg(3'd7, 32'd0, "rstAddr7");
    checkOutput(SEL_OUT, 0, 32'd0, "rstOutIdle");

    waitCycles(3);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      nChecks++;
      $display("[TB] FAIL %s: expectation for cycle %0d never sampled", e.name, e.cycle);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
